// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 round sequencer: state encoding, round counts and the
// per-round message-word index function.
package md5_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StInit,
      StRound,
      StFinal,
      StDone
   } md5_state_e;

   localparam int unsigned NUM_ROUNDS      = 64;
   localparam int unsigned ROUNDS_PER_PASS = 16;

   // Message word g for round i; only i mod 16 matters once the pass is known.
   function automatic logic [3:0] md5_msg_idx(input logic [5:0] round_idx);
      logic [1:0] pass_sel;
      logic [3:0] lo;
      pass_sel = 2'(round_idx / 6'(ROUNDS_PER_PASS));
      lo       = round_idx[3:0];
      unique case (pass_sel)
         2'd0:    md5_msg_idx = lo;
         2'd1:    md5_msg_idx = 4'(lo * 4'd5 + 4'd1);
         2'd2:    md5_msg_idx = 4'(lo * 4'd3 + 4'd5);
         default: md5_msg_idx = 4'(lo * 4'd7);
      endcase
   endfunction

endpackage

// File: rtl/md5_round_sequencer.sv
// Control FSM for one MD5 hashing unit: IV load, 64 rounds, final digest accumulate.
// Optional stall input enabled by defining MD5_ROUND_SEQUENCER_HOLD_EN.
module md5_round_sequencer
   import md5_pkg::*;
#(
   parameter int unsigned ROUND_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       soft_reset,
`ifdef MD5_ROUND_SEQUENCER_HOLD_EN
   input  logic       hold,
`endif
   output logic       init_load,
   output logic       round_en,
   output logic [5:0] round_idx,
   output logic [1:0] pass,
   output logic [3:0] msg_idx,
   output logic       final_add,
   output logic       busy,
   output logic       done
);

   localparam logic [3:0] SubLast   = 4'(ROUND_CYCLES - 1);
   localparam logic [5:0] LastRound = 6'(NUM_ROUNDS - 1);

   md5_state_e state_q, state_d;
   logic [3:0] sub_q, sub_d;
   logic [5:0] round_q, round_d;
   logic       hold_w;

`ifdef MD5_ROUND_SEQUENCER_HOLD_EN
   assign hold_w = hold;
`else
   assign hold_w = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      sub_d    = sub_q;
      round_d  = round_q;
      round_en = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StInit;
               sub_d   = '0;
               round_d = '0;
            end
         end
         StInit: begin
            state_d = StRound;
            sub_d   = '0;
            round_d = '0;
         end
         StRound: begin
            if (!hold_w) begin
               if (sub_q == SubLast) begin
                  round_en = 1'b1;
                  sub_d    = '0;
                  // round_idx parks at 63 through FINAL/DONE rather than wrapping.
                  if (round_q == LastRound) begin
                     state_d = StFinal;
                  end else begin
                     round_d = round_q + 6'd1;
                  end
               end else begin
                  sub_d = sub_q + 4'd1;
               end
            end
         end
         StFinal: state_d = StDone;
         default: state_d = StIdle;
      endcase
      if (soft_reset) begin
         state_d = StIdle;
         sub_d   = '0;
         round_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         sub_q   <= '0;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         sub_q   <= sub_d;
         round_q <= round_d;
      end
   end

   assign init_load = (state_q == StInit);
   assign final_add = (state_q == StFinal);
   assign busy      = (state_q == StInit) || (state_q == StRound) || (state_q == StFinal);
   assign done      = (state_q == StDone);
   assign round_idx = round_q;
   assign pass      = round_q[5:4];
   assign msg_idx   = md5_msg_idx(round_q);

endmodule
